// File: rtl/dmem_stall_ctrl.sv
// Multi-cycle data memory with a stall handshake, byte-enabled stores and sticky
// detection of misaligned or out-of-range accesses.
module dmem_stall_ctrl #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned RD_LAT = 2,
   parameter int unsigned WR_LAT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   input  logic                req_we,
   input  logic [31:0]         req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                stall,
   output logic                rd_valid,
   output logic [DATA_W-1:0]   rd_data,
   output logic                err,
   output logic [31:0]         err_addr
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned NB = DATA_W / 8;
   localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);
   // BUSY counts down to zero, so it is entered with latency-2.
   localparam logic [2:0] RD_CNT = (RD_LAT > 1) ? 3'(RD_LAT - 2) : 3'd0;
   localparam logic [2:0] WR_CNT = (WR_LAT > 1) ? 3'(WR_LAT - 2) : 3'd0;

   typedef enum logic [1:0] {StIdle, StBusy, StDone} stateT;

   logic [DATA_W-1:0] mem [DEPTH];

   stateT             stateQ, stateD;
   logic [2:0]        cntQ, cntD;
   logic              reqWeQ;
   logic [AW-1:0]     reqIdxQ;
   logic [DATA_W-1:0] reqWdataQ;
   logic [NB-1:0]     reqBeQ;
   logic              rdValidQ;
   logic [DATA_W-1:0] rdDataQ;
   logic              errQ;
   logic [31:0]       errAddrQ;

   logic              reqBad;
   logic [AW-1:0]     reqIdx;
   logic              memWe;
   logic [AW-1:0]     memIdx;
   logic [DATA_W-1:0] memWdata;
   logic [NB-1:0]     memBe;
   logic              rdLoad;
   logic [AW-1:0]     rdIdx;
   logic              setErr;

   assign reqIdx = req_addr[AW+1:2];
   assign reqBad = (req_addr[1:0] != 2'b00) || (req_addr >= ADDR_LIMIT);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stateQ <= StIdle;
         cntQ   <= 3'd0;
      end else begin
         stateQ <= stateD;
         cntQ   <= cntD;
      end
   end

   always_comb begin
      stateD = stateQ;
      cntD   = cntQ;
      unique case (stateQ)
         StIdle: begin
            if (req_valid && !reqBad) begin
               if (req_we) begin
                  if (WR_LAT > 1) begin
                     stateD = StBusy;
                     cntD   = WR_CNT;
                  end else begin
                     stateD = StDone;
                  end
               end else begin
                  if (RD_LAT > 1) begin
                     stateD = StBusy;
                     cntD   = RD_CNT;
                  end else begin
                     stateD = StDone;
                  end
               end
            end
         end
         StBusy: begin
            if (cntQ == 3'd0) stateD = StDone;
            else              cntD   = cntQ - 3'd1;
         end
         StDone:  stateD = StIdle;
         default: stateD = StIdle;
      endcase
   end

   always_comb begin
      stall    = 1'b0;
      memWe    = 1'b0;
      memIdx   = reqIdxQ;
      memWdata = reqWdataQ;
      memBe    = reqBeQ;
      rdLoad   = 1'b0;
      rdIdx    = reqIdxQ;
      setErr   = 1'b0;
      unique case (stateQ)
         StIdle: begin
            if (req_valid) begin
               if (reqBad) begin
                  setErr = 1'b1;
               end else if (req_we) begin
                  if (WR_LAT > 1) begin
                     stall = 1'b1;
                  end else begin
                     memWe    = 1'b1;
                     memIdx   = reqIdx;
                     memWdata = req_wdata;
                     memBe    = req_be;
                  end
               end else begin
                  if (RD_LAT > 1) begin
                     stall = 1'b1;
                  end else begin
                     rdLoad = 1'b1;
                     rdIdx  = reqIdx;
                  end
               end
            end
         end
         StBusy: begin
            stall = 1'b1;
            if (cntQ == 3'd0) begin
               if (reqWeQ) memWe  = 1'b1;
               else        rdLoad = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reqWeQ    <= 1'b0;
         reqIdxQ   <= '0;
         reqWdataQ <= '0;
         reqBeQ    <= '0;
         rdValidQ  <= 1'b0;
         rdDataQ   <= '0;
         errQ      <= 1'b0;
         errAddrQ  <= 32'd0;
      end else begin
         if (stateQ == StIdle && req_valid) begin
            reqWeQ    <= req_we;
            reqIdxQ   <= reqIdx;
            reqWdataQ <= req_wdata;
            reqBeQ    <= req_be;
         end
         rdValidQ <= rdLoad;
         if (rdLoad) rdDataQ <= mem[rdIdx];
         if (setErr) begin
            errQ <= 1'b1;
            if (!errQ) errAddrQ <= req_addr;
         end
      end
   end

   // The array is never reset; rst gating keeps a request seen during reset out of it.
   always_ff @(posedge clk) begin
      if (memWe && rst) begin
         for (int b = 0; b < NB; b++) begin
            if (memBe[b]) mem[memIdx][8*b +: 8] <= memWdata[8*b +: 8];
         end
      end
   end

   assign rd_valid = rdValidQ;
   assign rd_data  = rdDataQ;
   assign err      = errQ;
   assign err_addr = errAddrQ;

endmodule
